// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-stated data memory target for the pipeline MEM stage.
// Range checking is enabled by defining DMEM_BOUNDS_CHECK_EN.
module data_mem_responder #(
    parameter int LEN         = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_BASE   = 1024
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           mem_read,
    input  logic           mem_write,
    input  logic [LEN-1:0] address,
    input  logic [LEN-1:0] wr_data,
    output logic [LEN-1:0] rd_data,
    output logic           ready,
    output logic           busy,
    output logic           err
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LEN-1:0] BASE = LEN'(ADDR_BASE);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             wr_q, wr_d;
    logic             both_q, both_d;
    logic [LEN-1:0]   addr_q, addr_d;
    logic [LEN-1:0]   wdata_q, wdata_d;
    logic [LEN-1:0]   rd_data_q, rd_data_d;
    logic             err_q, err_d;
    logic [LEN-1:0]   mem_q [DEPTH];
    logic [LEN-1:0]   mem_d [DEPTH];

    logic             req;
    logic             commit;
    logic             in_idle;
    logic             op_wr;
    logic             op_both;
    logic [LEN-1:0]   op_addr;
    logic [LEN-1:0]   op_data;
    logic [LEN-1:0]   offset;
    logic [IDX_W-1:0] idx;
    logic             oor;
`ifdef DMEM_BOUNDS_CHECK_EN
    logic [LEN-1:0]   word;
`else
    logic             unused_bits;
`endif

    assign req     = mem_read | mem_write;
    assign in_idle = (state_q == S_IDLE);

    // With zero wait states the commit edge is the acceptance edge,
    // so the live inputs stand in for the not-yet-latched copies.
    assign op_wr   = in_idle ? mem_write : wr_q;
    assign op_both = in_idle ? (mem_read & mem_write) : both_q;
    assign op_addr = in_idle ? address : addr_q;
    assign op_data = in_idle ? wr_data : wdata_q;

    assign offset  = op_addr - BASE;
    assign idx     = offset[IDX_W+1:2];

`ifdef DMEM_BOUNDS_CHECK_EN
    assign word = offset >> 2;
    assign oor  = (op_addr < BASE) || (word >= LEN'(DEPTH));
`else
    assign oor         = 1'b0;
    assign unused_bits = ^{offset[LEN-1:IDX_W+2], offset[1:0]};
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        both_d    = both_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_data_d = rd_data_q;
        err_d     = 1'b0;
        mem_d     = mem_q;
        commit    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    wr_d    = mem_write;
                    both_d  = mem_read & mem_write;
                    addr_d  = address;
                    wdata_d = wr_data;
                    cnt_d   = WAIT_INIT;
                    if (WAIT_INIT == 4'd0) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (!req) begin
                    state_d = S_IDLE;
                end else if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (commit) begin
            err_d = op_both | oor;
            if (op_wr) begin
                if (!oor) begin
                    mem_d[idx] = op_data;
                end
            end else begin
                rd_data_d = oor ? '0 : mem_q[idx];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            both_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_data_q <= '0;
            err_q     <= 1'b0;
            mem_q     <= '{default: '0};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            both_q    <= both_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_data_q <= rd_data_d;
            err_q     <= err_d;
            mem_q     <= mem_d;
        end
    end

    assign rd_data = rd_data_q;
    assign ready   = (state_q == S_RESP);
    assign busy    = (state_q != S_IDLE);
    assign err     = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed table, hand-written
// corner sequences and randomized ops against a word-array reference model.
module tb_data_mem_responder;
    localparam int W = 2;
`ifdef DMEM_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic        ready;
    logic        busy;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem_m [64];
    logic [31:0] last_rd;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [9];

    data_mem_responder dut (
        .clock    (clock),
        .reset    (reset),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .address  (address),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .ready    (ready),
        .busy     (busy),
        .err      (err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 64; i++) mem_m[i] = '0;
        last_rd = '0;
    endfunction

    // Expected outcome of one op computed from the address-map rules.
    function automatic void model_op(input logic wr, input logic rd,
                                     input logic [31:0] a, input logic [31:0] d,
                                     output logic [31:0] erd,
                                     output logic eerr);
        logic [31:0] off;
        logic [31:0] w;
        logic        oor;
        int          slot;
        off  = a - 32'd1024;
        w    = off / 4;
        slot = int'(w % 64);
        oor  = BC && ((a < 32'd1024) || (w >= 32'd64));
        eerr = (wr && rd) || oor;
        if (wr) begin
            if (!oor) mem_m[slot] = d;
        end else begin
            last_rd = oor ? 32'd0 : mem_m[slot];
        end
        erd = last_rd;
    endfunction

    // Called at a negedge; returns at the negedge after the ready pulse.
    task automatic do_op(input logic wr, input logic rd, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] o_rd,
                         output logic o_err, output int lat);
        mem_write = wr;
        mem_read  = rd;
        address   = a;
        wr_data   = d;
        lat       = 0;
        o_rd      = '0;
        o_err     = 1'b0;
        while (lat < 20) begin
            @(negedge clock);
            lat++;
            if (lat == 1) check("busy_in_wait", 32'(busy), 32'd1);
            if (ready) break;
        end
        o_rd      = rd_data;
        o_err     = err;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        @(negedge clock);
        check("ready_one_cycle", 32'(ready), 32'd0);
        check("err_one_cycle", 32'(err), 32'd0);
    endtask

    initial begin
        logic [31:0] o_rd, erd, rd1, rd2;
        logic        o_err, eerr;
        int          lat, t, t1, t2, saw;
        logic        wr, rd;
        logic [31:0] a, d;
        int          r;

        tbl[0] = '{1'b0, 1'b1, 32'd1024, 32'd0,          32'd0,          1'b0};
        tbl[1] = '{1'b1, 1'b0, 32'd1028, 32'hDEADBEEF,   32'd0,          1'b0};
        tbl[2] = '{1'b0, 1'b1, 32'd1028, 32'd0,          32'hDEADBEEF,   1'b0};
        tbl[3] = '{1'b1, 1'b1, 32'd1036, 32'hA5A5A5A5,   32'hDEADBEEF,   1'b1};
        tbl[4] = '{1'b0, 1'b1, 32'd1036, 32'd0,          32'hA5A5A5A5,   1'b0};
        tbl[5] = '{1'b1, 1'b0, 32'd1280, 32'd1,          32'hA5A5A5A5,   BC};
        tbl[6] = '{1'b0, 1'b1, 32'd1024, 32'd0,          BC ? 32'd0 : 32'd1, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 32'd1276, 32'd0,          32'd0,          1'b0};
        tbl[8] = '{1'b0, 1'b1, 32'd1022, 32'd0,          32'd0,          BC};

        model_clear();
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            do_op(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].data,
                  o_rd, o_err, lat);
            model_op(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].data,
                     erd, eerr);
            check($sformatf("tbl%0d_lat", i), lat, W + 1);
            check($sformatf("tbl%0d_rd", i), o_rd, tbl[i].exp_rd);
            check($sformatf("tbl%0d_err", i), 32'(o_err), 32'(tbl[i].exp_err));
        end

        // Abort: store withdrawn during WAIT must leave no trace.
        mem_write = 1'b1;
        address   = 32'd1032;
        wr_data   = 32'h12345678;
        @(negedge clock);
        check("abort_busy", 32'(busy), 32'd1);
        mem_write = 1'b0;
        saw = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            if (k == 0) check("abort_idle", 32'(busy), 32'd0);
            if (ready) saw++;
        end
        check("abort_no_ready", saw, 0);
        do_op(1'b0, 1'b1, 32'd1032, 32'd0, o_rd, o_err, lat);
        model_op(1'b0, 1'b1, 32'd1032, 32'd0, erd, eerr);
        check("abort_load", o_rd, 32'd0);
        check("abort_load_lat", lat, W + 1);

        // Back-to-back loads with the request held continuously.
        mem_read = 1'b1;
        address  = 32'd1024;
        t  = 0;
        t1 = -1;
        t2 = -1;
        rd1 = '0;
        rd2 = '0;
        while (t < 30 && t2 < 0) begin
            @(negedge clock);
            t++;
            if (ready) begin
                if (t1 < 0) begin
                    t1  = t;
                    rd1 = rd_data;
                    address = 32'd1028;
                end else begin
                    t2  = t;
                    rd2 = rd_data;
                    mem_read = 1'b0;
                end
            end
        end
        mem_read = 1'b0;
        check("b2b_first_lat", t1, W + 1);
        check("b2b_spacing", t2 - t1, W + 2);
        model_op(1'b0, 1'b1, 32'd1024, 32'd0, erd, eerr);
        check("b2b_rd0", rd1, erd);
        model_op(1'b0, 1'b1, 32'd1028, 32'd0, erd, eerr);
        check("b2b_rd1", rd2, erd);
        @(negedge clock);

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            wr = (r <= 4);
            rd = (r == 0) || (r >= 5);
            a = 32'd1008 + 32'($urandom_range(0, 300));
            d = $urandom;
            do_op(wr, rd, a, d, o_rd, o_err, lat);
            model_op(wr, rd, a, d, erd, eerr);
            check($sformatf("rnd%0d_lat", i), lat, W + 1);
            check($sformatf("rnd%0d_rd@%0d", i, a), o_rd, erd);
            check($sformatf("rnd%0d_err", i), 32'(o_err), 32'(eerr));
        end

        // Reset asserted during the WAIT of a store.
        mem_write = 1'b1;
        address   = 32'd1040;
        wr_data   = 32'hCAFEF00D;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready", 32'(ready), 32'd0);
        check("midrst_rd_data", rd_data, 32'd0);
        reset     = 1'b1;
        mem_write = 1'b0;
        model_clear();
        do_op(1'b0, 1'b1, 32'd1040, 32'd0, o_rd, o_err, lat);
        check("midrst_no_store", o_rd, 32'd0);
        do_op(1'b0, 1'b1, 32'd1028, 32'd0, o_rd, o_err, lat);
        check("midrst_cleared", o_rd, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
